// File: rtl/cam_pkg.sv
// Shared definitions for the camera filter debug path: capture FSM encoding,
// status bit positions, default frame geometry and filter mode codes.
package cam_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARMED   = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_DRAIN   = 2'd3
  } cap_state_e;

  localparam int STAT_OVERFLOW = 0;
  localparam int STAT_STALE    = 1;
  localparam int STAT_SHORT    = 2;
  localparam int STAT_W        = 3;

  localparam int DEF_IMG_W = 640;
  localparam int DEF_IMG_H = 480;

  typedef enum logic [1:0] {
    FILT_SOBEL    = 2'd0,
    FILT_GAUSSIAN = 2'd1,
    FILT_CANNY    = 2'd2
  } filter_mode_e;

  // Out-of-range channel requests fall back to the last implemented channel.
  function automatic int clamp_ch(input int sel, input int num_ch);
    return (sel >= num_ch) ? num_ch - 1 : sel;
  endfunction

endpackage

// File: rtl/capture_fifo.sv
// Synchronous first-word-fall-through FIFO; the head is visible whenever not empty,
// and the last popped word is held on dout while empty.
module capture_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16
) (
  input  logic              clk_25MHz,
  input  logic              rst,
  input  logic              flush,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout,
  output logic              full,
  output logic              empty
);

  localparam int AW = $clog2(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW:0]       wr_ptr, rd_ptr;
  logic [DATA_W-1:0] last_q;
  logic              push_ok, pop_ok;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr ^ rd_ptr) == {1'b1, {AW{1'b0}}};
  assign pop_ok  = pop && !empty;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign push_ok = push && (!full || pop_ok);
  assign dout    = empty ? last_q : mem[rd_ptr[AW-1:0]];

  // NOTE: storage has no reset; only pointers define validity, and leaving the array
  // unreset lets it map onto plain RAM cells.
  always_ff @(posedge clk_25MHz) begin
    if (push_ok && !flush) mem[wr_ptr[AW-1:0]] <= din;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk_25MHz or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      last_q <= '0;
    end else begin
      if (pop_ok) last_q <= mem[rd_ptr[AW-1:0]];
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (push_ok) wr_ptr <= wr_ptr + 1'b1;
        if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      end
    end
  end

endmodule

// File: rtl/filter_frame_capture.sv
// Frame-dump unit: captures one frame of the selected filter channel into a FIFO,
// accumulating a checksum and sticky status flags along the way.
module filter_frame_capture
  import cam_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int NUM_CH     = 3,
  parameter int IMG_W      = DEF_IMG_W,
  parameter int IMG_H      = DEF_IMG_H,
  parameter int FIFO_DEPTH = 16,
  localparam int SEL_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                     clk_25MHz,
  input  logic                     rst,
  input  logic                     arm,
  input  logic                     abort,
  input  logic [SEL_W-1:0]         ch_sel,
  input  logic                     frame_start,
  input  logic                     pixel_valid,
  input  logic [NUM_CH*DATA_W-1:0] ch_data,
  input  logic [NUM_CH-1:0]        ch_ready,
  output logic [DATA_W-1:0]        out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     busy,
  output logic                     done,
  output logic [31:0]              checksum,
  output logic [STAT_W-1:0]        status
);

  localparam int FRAME_PX = IMG_W * IMG_H;
  localparam int CNT_W    = $clog2(FRAME_PX + 1);

  cap_state_e        state;
  logic [SEL_W-1:0]  sel_q;
  logic [CNT_W-1:0]  px_cnt, px_cnt_inc;
  logic [DATA_W-1:0] sample;
  logic              sample_ready, take_px, frame_end;
  logic              fifo_full, fifo_empty, pop;

  assign sample_ready = ch_ready[sel_q];
  assign px_cnt_inc   = px_cnt + CNT_W'(1);
  assign frame_end    = (px_cnt_inc == CNT_W'(FRAME_PX));
  assign out_valid    = !fifo_empty;
  assign pop          = out_valid && out_ready;
  assign busy         = (state != ST_IDLE);

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    sample  = '0;
    take_px = 1'b0;
    if (sample_ready) sample = ch_data[sel_q*DATA_W +: DATA_W];
    // The frame_start pixel opens a capture from ARMED but terminates one in CAPTURE.
    if (pixel_valid && !abort) begin
      take_px = (state == ST_ARMED   &&  frame_start) ||
                (state == ST_CAPTURE && !frame_start);
    end
  end

  always_ff @(posedge clk_25MHz or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      sel_q    <= '0;
      px_cnt   <= '0;
      checksum <= '0;
      status   <= '0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      if (abort) begin
        state <= ST_IDLE;
      end else begin
        case (state)
          ST_IDLE: if (arm) begin
            state    <= ST_ARMED;
            sel_q    <= SEL_W'(clamp_ch(int'(ch_sel), NUM_CH));
            px_cnt   <= '0;
            checksum <= '0;
            status   <= '0;
          end
          ST_ARMED: if (frame_start) begin
            state <= (take_px && frame_end) ? ST_DRAIN : ST_CAPTURE;
          end
          ST_CAPTURE: if (frame_start) begin
            status[STAT_SHORT] <= 1'b1;
            state              <= ST_DRAIN;
          end else if (take_px && frame_end) begin
            state <= ST_DRAIN;
          end
          ST_DRAIN: if (fifo_empty) begin
            state <= ST_IDLE;
            done  <= 1'b1;
          end
          default: state <= ST_IDLE;
        endcase

        if (take_px) begin
          px_cnt   <= px_cnt_inc;
          checksum <= checksum + 32'(sample);
          if (!sample_ready)       status[STAT_STALE]    <= 1'b1;
          if (fifo_full && !pop)   status[STAT_OVERFLOW] <= 1'b1;
        end
      end
    end
  end

  capture_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk_25MHz (clk_25MHz),
    .rst       (rst),
    .flush     (abort),
    .push      (take_px),
    .pop       (pop),
    .din       (sample),
    .dout      (out_data),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

endmodule

// File: tb/tb_filter_frame_capture.sv
// Bench for filter_frame_capture: directed frame scenarios plus randomized frames,
// compared every cycle against a queue-based model of the capture behaviour.
module tb_filter_frame_capture;

  localparam int DATA_W = 8, NUM_CH = 3, IMG_W = 4, IMG_H = 2, FIFO_DEPTH = 4;
  localparam int FRAME = IMG_W * IMG_H;
  localparam int PH_IDLE = 0, PH_ARMED = 1, PH_CAPTURE = 2, PH_DRAIN = 3;

  logic        clk_25MHz = 1'b0;
  logic        rst, arm, abort, frame_start, pixel_valid, out_ready;
  logic [1:0]  ch_sel;
  logic [23:0] ch_data;
  logic [2:0]  ch_ready;
  logic [7:0]  out_data;
  logic        out_valid, busy, done;
  logic [31:0] checksum;
  logic [2:0]  status;

  int tests = 0, fails = 0;

  // reference model state
  logic [7:0]  mq[$];
  logic [7:0]  m_last;
  int          m_ph, m_sel, m_cnt;
  logic [31:0] m_sum;
  logic [2:0]  m_st;
  bit          m_done;

  logic [7:0]  pops[$];
  logic [7:0]  exp_q[$];
  int          done_seen;

  always #20 clk_25MHz = ~clk_25MHz;

  filter_frame_capture #(
    .DATA_W(DATA_W), .NUM_CH(NUM_CH), .IMG_W(IMG_W), .IMG_H(IMG_H), .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clk_25MHz(clk_25MHz), .rst(rst), .arm(arm), .abort(abort), .ch_sel(ch_sel),
    .frame_start(frame_start), .pixel_valid(pixel_valid), .ch_data(ch_data),
    .ch_ready(ch_ready), .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .busy(busy), .done(done), .checksum(checksum), .status(status)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_last = '0; m_ph = PH_IDLE; m_sel = 0; m_cnt = 0; m_sum = '0; m_st = '0; m_done = 0;
  endtask

  // One clock edge of the behavioural model, using the inputs as driven before the edge.
  task automatic model_edge();
    bit pop, full, take;
    logic [7:0] s;
    m_done = 0;
    take   = 0;
    if (rst) begin model_reset(); return; end
    pop  = (mq.size() != 0) && out_ready;
    full = (mq.size() == FIFO_DEPTH);
    if (abort) begin
      if (pop) m_last = mq[0];
      mq.delete();
      m_ph = PH_IDLE;
      return;
    end
    case (m_ph)
      PH_IDLE: if (arm) begin
        m_ph = PH_ARMED; m_sel = (ch_sel >= NUM_CH) ? NUM_CH - 1 : int'(ch_sel);
        m_cnt = 0; m_sum = '0; m_st = '0;
      end
      PH_ARMED: if (frame_start) begin m_ph = PH_CAPTURE; take = pixel_valid; end
      PH_CAPTURE: if (frame_start) begin m_st[2] = 1'b1; m_ph = PH_DRAIN; end
                  else take = pixel_valid;
      default: if (mq.size() == 0) begin m_ph = PH_IDLE; m_done = 1; end
    endcase
    if (pop) m_last = mq.pop_front();
    if (take) begin
      s = ch_ready[m_sel] ? ch_data[m_sel*8 +: 8] : 8'h00;
      if (!ch_ready[m_sel]) m_st[1] = 1'b1;
      m_cnt++;
      m_sum += 32'(s);
      if (!full || pop) mq.push_back(s);
      else m_st[0] = 1'b1;
      if (m_cnt == FRAME) m_ph = PH_DRAIN;
    end
  endtask

  task automatic check_outputs();
    check("out_valid", out_valid, (mq.size() != 0));
    check("out_data",  out_data,  (mq.size() != 0) ? mq[0] : m_last);
    check("busy",      busy,      (m_ph != PH_IDLE));
    check("done",      done,      m_done);
    check("checksum",  checksum,  m_sum);
    check("status",    status,    m_st);
  endtask

  // Called at a falling edge with inputs already driven; returns at the next falling edge.
  task automatic tick();
    if (out_valid && out_ready) pops.push_back(out_data);
    @(posedge clk_25MHz);
    model_edge();
    #1;
    check_outputs();
    if (done) done_seen++;
    @(negedge clk_25MHz);
  endtask

  task automatic px(input int c, input logic [7:0] v, input bit rdy, input bit fs);
    ch_data = 24'($urandom);
    ch_data[c*8 +: 8] = v;
    ch_ready = 3'b111;
    ch_ready[c] = rdy;
    pixel_valid = 1'b1; frame_start = fs;
    tick();
    pixel_valid = 1'b0; frame_start = 1'b0;
  endtask

  task automatic arm_ch(input logic [1:0] sel);
    ch_sel = sel; arm = 1'b1;
    tick();
    arm = 1'b0; ch_sel = 2'($urandom);
  endtask

  task automatic wait_idle(input int budget, input bit rnd);
    int n = 0;
    while (!(m_ph == PH_IDLE && mq.size() == 0)) begin
      if (n == budget) begin
        check("drain_timeout", m_ph, PH_IDLE);
        return;
      end
      if (rnd) begin
        out_ready = 1'($urandom); pixel_valid = 1'($urandom);
        ch_data = 24'($urandom); ch_ready = 3'b111;
      end
      n++;
      tick();
    end
    pixel_valid = 1'b0;
  endtask

  task automatic check_pops(input string tag);
    check({tag, "_len"}, pops.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < pops.size(); i++) check(tag, pops[i], exp_q[i]);
  endtask

  task automatic start_case();
    pops.delete(); exp_q.delete(); done_seen = 0;
  endtask

  initial begin
    logic [31:0] sum;
    logic [7:0]  v;
    #5_000_000;
    $display("FAIL global_timeout: simulation did not finish, required $finish before limit");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] sum;
    logic [7:0]  v;
    rst = 1'b1; arm = 0; abort = 0; frame_start = 0; pixel_valid = 0; out_ready = 0;
    ch_sel = '0; ch_data = '0; ch_ready = '0;
    model_reset();
    @(negedge clk_25MHz);
    check_outputs();
    check("rst_out_data", out_data, 8'h00);
    tick();
    rst = 1'b0;

    // 1: full frame streamed straight through
    start_case(); out_ready = 1'b1;
    arm_ch(2'd1);
    for (int i = 1; i <= 8; i++) px(1, 8'(i), 1'b1, i == 1);
    wait_idle(30, 0);
    for (int i = 1; i <= 8; i++) exp_q.push_back(8'(i));
    check_pops("t1_seq");
    check("t1_checksum", checksum, 32'd36);
    check("t1_status", status, 3'b000);
    check("t1_done_cnt", done_seen, 1);
    check("t1_busy", busy, 1'b0);

    // 2: consumer stalled, FIFO overflows
    start_case(); out_ready = 1'b0;
    arm_ch(2'd1);
    for (int i = 1; i <= 8; i++) px(1, 8'(i), 1'b1, i == 1);
    tick(); tick();
    check("t2_status", status, 3'b001);
    check("t2_checksum", checksum, 32'd36);
    check("t2_busy_stalled", busy, 1'b1);
    out_ready = 1'b1;
    wait_idle(30, 0);
    for (int i = 1; i <= 4; i++) exp_q.push_back(8'(i));
    check_pops("t2_seq");
    check("t2_done_cnt", done_seen, 1);

    // 3: stale channel zeroes one sample
    start_case();
    arm_ch(2'd2);
    for (int i = 1; i <= 8; i++) px(2, 8'h10, i != 3, i == 1);
    wait_idle(30, 0);
    exp_q = '{8'h10, 8'h10, 8'h00, 8'h10, 8'h10, 8'h10, 8'h10, 8'h10};
    check_pops("t3_seq");
    check("t3_status", status, 3'b010);
    check("t3_checksum", checksum, 32'h70);

    // 4: early frame_start cuts the frame short
    start_case(); sum = 0;
    arm_ch(2'd0);
    for (int i = 0; i < 5; i++) begin
      v = 8'($urandom); sum += 32'(v); exp_q.push_back(v);
      px(0, v, 1'b1, i == 0);
    end
    px(0, 8'hEE, 1'b1, 1'b1);
    wait_idle(30, 0);
    check_pops("t4_seq");
    check("t4_status", status, 3'b100);
    check("t4_checksum", checksum, sum);
    check("t4_done_cnt", done_seen, 1);

    // 5: abort mid-capture, then async reset mid-frame
    start_case(); out_ready = 1'b0;
    arm_ch(2'd1);
    for (int i = 0; i < 3; i++) px(1, 8'($urandom), 1'b1, i == 0);
    abort = 1'b1; tick(); abort = 1'b0;
    check("t5_abort_valid", out_valid, 1'b0);
    check("t5_abort_busy", busy, 1'b0);
    tick(); tick();
    check("t5_done_cnt", done_seen, 0);
    arm_ch(2'd1);
    px(1, 8'h5A, 1'b1, 1'b1);
    px(1, 8'hA5, 1'b1, 1'b0);
    #7 rst = 1'b1;
    #1 model_reset();
    check_outputs();
    check("t5_rst_checksum", checksum, 32'd0);
    check("t5_rst_out_data", out_data, 8'h00);
    @(negedge clk_25MHz);
    tick();
    rst = 1'b0;

    // 6: clamped channel select, arm while busy and pixels while armed are ignored
    start_case(); out_ready = 1'b1; sum = 0;
    arm_ch(2'd3);
    px(2, 8'h77, 1'b1, 1'b0);
    for (int i = 0; i < 8; i++) begin
      v = 8'h21 + 8'(i); sum += 32'(v); exp_q.push_back(v);
      if (i == 3) begin arm = 1'b1; ch_sel = 2'd0; end
      px(2, v, 1'b1, i == 0);
      arm = 1'b0;
    end
    wait_idle(30, 0);
    check_pops("t6_seq");
    check("t6_checksum", checksum, sum);
    check("t6_status", status, 3'b000);

    // randomized frames
    repeat (25) begin
      out_ready = 1'($urandom);
      arm_ch(2'($urandom));
      for (int k = 0; k < 14; k++) begin
        ch_data     = 24'($urandom);
        ch_ready    = ($urandom_range(0, 5) == 0) ? 3'($urandom) : 3'b111;
        pixel_valid = ($urandom_range(0, 3) != 0);
        frame_start = (k == 0) || ($urandom_range(0, 15) == 0);
        abort       = ($urandom_range(0, 39) == 0);
        out_ready   = 1'($urandom);
        tick();
      end
      pixel_valid = 1'b0; frame_start = 1'b0; abort = 1'b0;
      wait_idle(80, 1);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
